ex_div: RTL and testbench

//  Multi-cycle radix-2 restoring divider attached to the EX stage for DIV/DIVU.
//  EX launches an operation, holds its stall request while the divider iterates,
//  and consumes {remainder, quotient} for the HI/LO write when ready_o rises.
//  One quotient bit per cycle; the divider holds the pipeline for about 33 cycles per divide.

---
 rtl/ex_div.sv | 109 ++++++++++
 tb/tb_ex_div.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, {rem, quo} on result_o.
// Latency DATA_W+1 edges (2 for divide-by-zero); EX holds start_i until ready_o, dropping it aborts.
module ex_div #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_BUSY, S_DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] rem;
  logic              sign_q;
  logic              sign_r;

  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W:0]   partial;
  logic [DATA_W:0]   diff;
  logic              qbit;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] quo_fix;

  always_comb begin
    abs1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    abs2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    // dvd shifts dividend bits out the top while quotient bits enter at the bottom
    partial = {rem, dvd[DATA_W-1]};
    diff    = partial - {1'b0, dvs};
    qbit    = ~diff[DATA_W];
    rem_nxt = qbit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
    quo_nxt = {dvd[DATA_W-2:0], qbit};
    rem_fix = sign_r ? -rem_nxt : rem_nxt;
    quo_fix = sign_q ? -quo_nxt : quo_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            dvd    <= abs1;
            dvs    <= abs2;
            rem    <= '0;
            cnt    <= '0;
            sign_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            sign_r <= signed_div_i & opdata1_i[DATA_W-1];
            state  <= (opdata2_i == '0) ? S_BYZERO : S_BUSY;
          end
        end
        S_BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
          state    <= S_DONE;
        end
        S_BUSY: begin
          if (annul_i || !start_i) begin
            state <= S_IDLE;
          end else begin
            rem <= rem_nxt;
            dvd <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(DATA_W-1)) begin
              result_o <= {rem_fix, quo_fix};
              ready_o  <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!start_i || annul_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: driver queues expected {rem, quo} and completion cycle, monitor checks.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  ex_div #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_rdy = 1'b0;

  always @(posedge clk) cyc++;

  // Reference: plain 64-bit arithmetic, which truncates toward zero and avoids the 32-bit overflow case.
  function automatic logic [63:0] model(bit sd, logic [31:0] a, logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sd) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = {32'd0, a};
      y = {32'd0, b};
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && ready_o && !prev_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result_o, e.res);
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_rdy = rst ? 1'b0 : ready_o;
  end

  task automatic launch(bit sd, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
  endtask

  task automatic run_op(bit sd, logic [31:0] a, logic [31:0] b, int hold);
    int          waited;
    logic [63:0] held;
    launch(sd, a, b);
    exp_q.push_back('{res: model(sd, a, b), cyc: cyc + ((b == 32'd0) ? 2 : 33)});
    waited = 0;
    while (!ready_o && waited < 60) begin
      @(negedge clk);
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      waited++;
    end
    if (!ready_o) begin
      check("ready_timeout", 64'd0, 64'd1);
      exp_q.delete();
    end else begin
      held = result_o;
      repeat (hold) begin
        @(negedge clk);
        check("done_hold_ready", 64'(ready_o), 64'd1);
        check("done_hold_result", result_o, held);
      end
      start_i = 1'b0;
      @(negedge clk);
      check("idle_after_done", {63'd0, ready_o} | result_o, 64'd0);
    end
  endtask

  // Abort after 10 BUSY edges, either by annul_i or by dropping start_i; no result may appear.
  task automatic abort_op(bit use_annul);
    bit seen;
    launch(1'b0, $urandom, 32'd5);
    repeat (10) @(negedge clk);
    if (use_annul) annul_i = 1'b1;
    else           start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    check(use_annul ? "annul_no_ready" : "startdrop_no_ready", 64'(seen), 64'd0);
  endtask

  // Reset between edges must clear outputs without waiting for a clock.
  task automatic reset_mid(bit in_done);
    int waited;
    launch(1'b1, 32'hFFFF_FC18, 32'd7);
    if (in_done) begin
      exp_q.push_back('{res: model(1'b1, 32'hFFFF_FC18, 32'd7), cyc: cyc + 33});
      waited = 0;
      while (!ready_o && waited < 60) begin
        @(negedge clk);
        waited++;
      end
      check("pre_reset_ready", 64'(ready_o), 64'd1);
      if (!ready_o) exp_q.delete();
    end else begin
      repeat (12) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1 check(in_done ? "rst_done_outputs" : "rst_busy_outputs", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
  endtask

  logic [31:0] dir_a[8] = '{32'd100, 32'hFFFF_FFF9, 32'd12345, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'd9, 32'hFFFF_FF9C, 32'd0};
  logic [31:0] dir_b[8] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF,
                            32'd1, 32'd3, 32'hFFFF_FFF9, 32'd0};
  bit          dir_s[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1 check("reset_outputs", {63'd0, ready_o} | result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("t1_model", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    for (int i = 0; i < 8; i++) run_op(dir_s[i], dir_a[i], dir_b[i], 0);

    abort_op(1'b1);
    run_op(1'b0, 32'd9, 32'd3, 0);
    abort_op(1'b0);
    run_op(1'b1, 32'd9, 32'hFFFF_FFFD, 0);

    run_op(1'b0, 32'd77, 32'd10, 5);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 3);

    reset_mid(1'b0);
    run_op(1'b0, 32'd1000, 32'd33, 0);
    reset_mid(1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 255);
        2:       b = -$urandom_range(1, 255);
        default: b = $urandom;
      endcase
      run_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
